mul_iter: RTL and testbench

- Parametrised iterative multiplier; next generation of the single-width multiplier wrapper.
- Retires STEP multiplier bits per cycle.
- Decodes the four RISC-V M-extension multiply ops: MUL, MULH, MULHSU, MULHU.
- Valid/ready on input and output, with output backpressure, flush, tag pass-through and a zero-operand early-out. Sits in the execute stage beside the divider.

---
 rtl/mul_pkg.sv | 30 +++
 rtl/mul_iter_if.sv | 29 ++
 rtl/mul_step.sv | 23 ++
 rtl/mul_iter.sv | 117 +++++++++++
 tb/tb_mul_iter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared op encodings, FSM states and signedness decode for mul_iter
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic sign_a;
    logic sign_b;
  } mul_sign_t;

  // MUL shares its low half with the unsigned product, so it is treated as u x u.
  function automatic mul_sign_t op_signs(input mul_op_e op);
    mul_sign_t s;
    s.sign_a = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    s.sign_b = (op == MUL_OP_MULH);
    return s;
  endfunction

endpackage

// File: rtl/mul_iter_if.sv
// rtl/mul_iter_if.sv - request/result handshake bundle for mul_iter
interface mul_iter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             invalid;
  logic             inready;
  logic [1:0]       op;
  logic [XLEN-1:0]  multiplicand;
  logic [XLEN-1:0]  multiplier;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic             outvalid;
  logic             outready;
  logic [XLEN-1:0]  result;
  logic [XLEN-1:0]  result_hi;
  logic [XLEN-1:0]  result_lo;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output invalid, op, multiplicand, multiplier, tag_in, flush, outready,
    input  inready, outvalid, result, result_hi, result_lo, tag_out
  );

  modport slave (
    input  invalid, op, multiplicand, multiplier, tag_in, flush, outready,
    output inready, outvalid, result, result_hi, result_lo, tag_out
  );
endinterface

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one iteration: acc + (|A| x digit) << shift
module mul_step #(
  parameter int XLEN = 32,
  parameter int STEP = 2,
  parameter int SH_W = 6
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_mcand,
  input  logic [STEP-1:0]   i_digit,
  input  logic [SH_W-1:0]   i_shamt,
  output logic [2*XLEN-1:0] o_acc
);
  logic [2*XLEN-1:0] w_pp;

  // Partial product of the magnitude with the current digit, then accumulate at its weight.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < STEP; i++) begin
      if (i_digit[i]) w_pp = w_pp + ({{XLEN{1'b0}}, i_mcand} << i);
    end
    o_acc = i_acc + (w_pp << i_shamt);
  end
endmodule

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative RISC-V M-extension multiplier with valid/ready, flush and tags
module mul_iter
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEP  = 2,
  parameter int TAG_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  mul_iter_if.slave  bus
);
  localparam int NSTEPS = XLEN / STEP;
  localparam int CNT_W  = $clog2(NSTEPS + 1);
  localparam int SH_W   = $clog2(2 * XLEN);

  mul_state_e        r_state;
  mul_state_e        w_state_nxt;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg;
  mul_op_e           r_op;
  logic [TAG_W-1:0]  r_tag;
  logic [CNT_W-1:0]  r_cnt;
  logic [SH_W-1:0]   r_shamt;

  mul_sign_t         w_signs;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_zero;
  logic              w_inready;
  logic              w_accept;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod;

  assign w_signs   = op_signs(mul_op_e'(bus.op));
  assign w_a_neg   = w_signs.sign_a & bus.multiplicand[XLEN-1];
  assign w_b_neg   = w_signs.sign_b & bus.multiplier[XLEN-1];
  assign w_a_mag   = w_a_neg ? -bus.multiplicand : bus.multiplicand;
  assign w_b_mag   = w_b_neg ? -bus.multiplier : bus.multiplier;
  assign w_zero    = (bus.multiplicand == '0) || (bus.multiplier == '0);
  assign w_inready = (r_state == IDLE) || ((r_state == DONE) && bus.outready);
  assign w_accept  = bus.invalid && w_inready && !bus.flush;

  mul_step #(
    .XLEN (XLEN),
    .STEP (STEP),
    .SH_W (SH_W)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_digit (r_mplier[STEP-1:0]),
    .i_shamt (r_shamt),
    .o_acc   (w_acc_next)
  );

  // Sign is re-applied on the way out so the accumulator only ever holds a magnitude.
  assign w_prod        = r_neg ? -r_acc : r_acc;
  assign bus.inready   = w_inready;
  assign bus.outvalid  = (r_state == DONE);
  assign bus.result_hi = w_prod[2*XLEN-1:XLEN];
  assign bus.result_lo = w_prod[XLEN-1:0];
  assign bus.result    = (r_op == MUL_OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign bus.tag_out   = r_tag;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state: flush wins, zero operands skip the iteration, DONE can chain a new op.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_accept) w_state_nxt = w_zero ? DONE : BUSY;
        BUSY: if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
        DONE: if (bus.outready) w_state_nxt = w_accept ? (w_zero ? DONE : BUSY) : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: load magnitudes on accept, then retire STEP multiplier bits per BUSY cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_op     <= MUL_OP_MUL;
      r_tag    <= '0;
      r_cnt    <= '0;
      r_shamt  <= '0;
    end else if (w_accept) begin
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_neg    <= w_zero ? 1'b0 : (w_a_neg ^ w_b_neg);
      r_op     <= mul_op_e'(bus.op);
      r_tag    <= bus.tag_in;
      r_cnt    <= CNT_W'(NSTEPS);
      r_shamt  <= '0;
    end else if ((r_state == BUSY) && !bus.flush) begin
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> STEP;
      r_cnt    <= r_cnt - CNT_W'(1);
      r_shamt  <= r_shamt + SH_W'(STEP);
    end
  end
endmodule

// File: tb/tb_mul_iter.sv
// tb/tb_mul_iter.sv - scoreboard bench for mul_iter with directed vectors
module tb_mul_iter;
  localparam int XLEN  = 32;
  localparam int STEP  = 2;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mul_iter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  mul_iter #(.XLEN(XLEN), .STEP(STEP), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  tag;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   seen = 1'b0;
  int   waited;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency on first outvalid, data/tag on each handshake.
  always @(negedge clk) begin
    if (rst && bus.outvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_outvalid: got outvalid=1 with no pending request at cycle %0d", cyc);
      end else begin
        if (!seen) begin
          check("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
          seen = 1'b1;
        end
        if (bus.outready) begin
          mon_e = sb.pop_front();
          check("result", {32'h0, bus.result}, {32'h0, mon_e.res});
          check("result_hi", {32'h0, bus.result_hi}, {32'h0, mon_e.hi});
          check("result_lo", {32'h0, bus.result_lo}, {32'h0, mon_e.lo});
          check("tag_out", {60'h0, bus.tag_out}, {60'h0, mon_e.tag});
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] r, input logic [31:0] h,
                       input logic [31:0] l, input int lat, output int n);
    n = 0;
    bus.invalid      = 1'b1;
    bus.op           = op;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.tag_in       = tag;
    @(negedge clk);
    while (!bus.inready && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL accept_timeout: got inready=0 for %0d cycles, required 1", n);
    end else begin
      sb.push_back('{r, h, l, tag, cyc, lat});
    end
    @(posedge clk);
    #1;
    bus.invalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.outvalid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.invalid      = 1'b0;
    bus.op           = 2'b00;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.tag_in       = '0;
    bus.flush        = 1'b0;
    bus.outready     = 1'b1;
    #1;
    check("reset_inready", {63'h0, bus.inready}, 64'h1);
    check("reset_outvalid", {63'h0, bus.outvalid}, 64'h0);
    check("reset_result", {32'h0, bus.result}, 64'h0);
    check("reset_result_hi", {32'h0, bus.result_hi}, 64'h0);
    check("reset_result_lo", {32'h0, bus.result_lo}, 64'h0);
    check("reset_tag_out", {60'h0, bus.tag_out}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Back-to-back stream of signed/unsigned cases.
    issue(2'b00, 32'd7, 32'd6, 4'h3, 32'd42, 32'd0, 32'd42, 17, waited);
    issue(2'b01, 32'hFFFF_FFFF, 32'd5, 4'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 17, waited);
    issue(2'b11, 32'hFFFF_FFFF, 32'd5, 4'h6, 32'h4, 32'h4, 32'hFFFF_FFFB, 17, waited);
    drain();
    issue(2'b10, 32'h8000_0000, 32'h8000_0000, 4'h7, 32'hC000_0000, 32'hC000_0000, 32'h0, 17, waited);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 4'h8, 32'h4000_0000, 32'h4000_0000, 32'h0, 17, waited);
    drain();

    // Zero early-out returns to IDLE.
    issue(2'b11, 32'h0, 32'h1234_5678, 4'h9, 32'h0, 32'h0, 32'h0, 1, waited);
    drain();
    check("zero_idle_inready", {63'h0, bus.inready}, 64'h1);
    check("zero_idle_outvalid", {63'h0, bus.outvalid}, 64'h0);

    // Backpressure: hold, then replace the held result in the same cycle.
    bus.outready = 1'b0;
    issue(2'b00, 32'd3, 32'd5, 4'hA, 32'd15, 32'd0, 32'd15, 17, waited);
    waited = 0;
    while (!bus.outvalid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_outvalid", {63'h0, bus.outvalid}, 64'h1);
      check("hold_inready", {63'h0, bus.inready}, 64'h0);
      check("hold_result", {32'h0, bus.result}, 64'd15);
      check("hold_tag", {60'h0, bus.tag_out}, 64'hA);
    end
    @(posedge clk);
    #1;
    bus.outready = 1'b1;
    issue(2'b11, 32'h0001_0000, 32'h0001_0000, 4'hB, 32'h1, 32'h1, 32'h0, 17, waited);
    check("b2b_same_cycle_accept", 64'(waited), 64'h0);
    drain();

    // Flush mid-BUSY discards the op.
    issue(2'b00, 32'h1234, 32'h5678, 4'hC, 32'h0, 32'h0, 32'h0, 17, waited);
    repeat (7) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_inready", {63'h0, bus.inready}, 64'h1);
    check("flush_outvalid", {63'h0, bus.outvalid}, 64'h0);
    repeat (20) @(posedge clk);
    #1;
    check("flush_no_result", {63'h0, bus.outvalid}, 64'h0);

    // Asynchronous reset mid-BUSY.
    issue(2'b01, 32'h7, 32'h9, 4'hD, 32'h0, 32'h0, 32'h0, 17, waited);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    void'(sb.pop_back());
    seen = 1'b0;
    #1;
    check("arst_inready", {63'h0, bus.inready}, 64'h1);
    check("arst_outvalid", {63'h0, bus.outvalid}, 64'h0);
    check("arst_result", {32'h0, bus.result}, 64'h0);
    check("arst_result_hi", {32'h0, bus.result_hi}, 64'h0);
    check("arst_result_lo", {32'h0, bus.result_lo}, 64'h0);
    check("arst_tag_out", {60'h0, bus.tag_out}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Recovery: -2 x -3 as MULH.
    issue(2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 4'hE, 32'h0, 32'h0, 32'd6, 17, waited);
    drain();
    check("final_queue_empty", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
